// File: rtl/platform_scheduler.sv
// platform_scheduler: 16-slot platform table; once per frame it scrolls every slot and respawns
// off-screen slots above the highest survivor. Define PLAT_SPRING_EN to add spring tracking.
module platform_scheduler #(
   parameter int          NUM_PLAT  = 16,
   parameter int          SCREEN_H  = 480,
   parameter int          XSPAN     = 360,
   parameter int          INIT_Y0   = 440,
   parameter int          INIT_STEP = 28,
   parameter int          GAP_EASY  = 40,
   parameter int          GAP_MED   = 60,
   parameter int          GAP_HARD  = 80,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         IDX_W     = $clog2(NUM_PLAT)
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  frame_clk,
   input  logic [5:0]            scroll_amt,
   input  logic [1:0]            difficulty,
   output logic [9*NUM_PLAT-1:0] plat_x_flat,
   output logic [9*NUM_PLAT-1:0] plat_y_flat,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun,
   output logic [15:0]           spawn_count,
   output logic                  spring_valid,
   output logic [IDX_W-1:0]      spring_slot
);
   typedef enum logic [2:0] {INIT, IDLE, SCROLL, SPAWN, DONE} state_t;

   localparam logic [15:0]      SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PLAT - 1);

   state_t           state, next_state;
   logic [8:0]       plat_x [NUM_PLAT];
   logic [8:0]       plat_y [NUM_PLAT];
   logic [IDX_W-1:0] idx;
   logic [15:0]      lfsr, lfsr_next;
   logic             fsync, fprev, frame_edge, idx_last;
   logic [5:0]       scroll_q;
   logic [1:0]       diff_q;
   logic [NUM_PLAT-1:0] dead;
   logic [9:0]       top, top_eff, gap, scroll_sum;
   logic [8:0]       spawn_y, init_y, new_x;
   logic             busy_d, done_d;

   function automatic logic [8:0] x_rule(input logic [8:0] r);
      return (r >= 9'(XSPAN)) ? r - 9'(XSPAN) : r;
   endfunction

   function automatic logic [9:0] gap_base(input logic [1:0] d);
      case (d)
         2'd0:    return 10'(GAP_EASY);
         2'd1:    return 10'(GAP_MED);
         default: return 10'(GAP_HARD);
      endcase
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign frame_edge = fsync & ~fprev;
   assign idx_last   = (idx == LAST);
   assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign new_x      = x_rule(lfsr[8:0]);
   assign init_y     = 9'(INIT_Y0 - int'(idx) * INIT_STEP);
   assign scroll_sum = {1'b0, plat_y[idx]} + {4'd0, scroll_q};
   // With no survivors top is still the 3FF sentinel; spawn relative to the screen bottom instead.
   assign top_eff    = (top == 10'h3FF) ? 10'(SCREEN_H) : top;
   assign gap        = gap_base(diff_q) + {6'd0, lfsr[3:0]};
   assign spawn_y    = (top_eff >= gap) ? 9'(top_eff - gap) : 9'd0;

   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= INIT;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         INIT:    if (idx_last)   next_state = DONE;
         IDLE:    if (frame_edge) next_state = SCROLL;
         SCROLL:  if (idx_last)   next_state = SPAWN;
         SPAWN:   if (idx_last)   next_state = DONE;
         DONE:                    next_state = IDLE;
         default:                 next_state = INIT;
      endcase
   end

   always_comb begin
      busy_d = (next_state != IDLE);
      done_d = (state == DONE);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_PLAT; i++) begin
            plat_x[i] <= '0;
            plat_y[i] <= '0;
         end
         lfsr        <= SEED;
         fsync       <= 1'b1;
         fprev       <= 1'b1;
         idx         <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         spawn_count <= '0;
         dead        <= '0;
         top         <= 10'h3FF;
         scroll_q    <= '0;
         diff_q      <= '0;
      end else begin
         fsync      <= frame_clk;
         fprev      <= fsync;
         busy       <= busy_d;
         frame_done <= done_d;
         if (frame_edge && state != IDLE) overrun <= 1'b1;
         case (state)
            INIT: begin
               plat_x[idx] <= new_x;
               plat_y[idx] <= init_y;
               lfsr        <= lfsr_next;
               idx         <= idx_last ? '0 : idx + 1'b1;
            end
            IDLE: if (frame_edge) begin
               scroll_q <= scroll_amt;
               diff_q   <= difficulty;
               dead     <= '0;
               top      <= 10'h3FF;
               idx      <= '0;
            end
            SCROLL: begin
               if (scroll_sum >= 10'(SCREEN_H)) dead[idx] <= 1'b1;
               else begin
                  plat_y[idx] <= scroll_sum[8:0];
                  if (scroll_sum < top) top <= scroll_sum;
               end
               idx <= idx_last ? '0 : idx + 1'b1;
            end
            SPAWN: begin
               if (dead[idx]) begin
                  plat_x[idx] <= new_x;
                  plat_y[idx] <= spawn_y;
                  top         <= {1'b0, spawn_y};
                  lfsr        <= lfsr_next;
                  spawn_count <= sat_inc(spawn_count);
               end
               idx <= idx_last ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef PLAT_SPRING_EN
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         spring_valid <= 1'b0;
         spring_slot  <= '0;
      end else if (state == SCROLL && scroll_sum >= 10'(SCREEN_H) && idx == spring_slot) begin
         spring_valid <= 1'b0;
      end else if (state == SPAWN && dead[idx] && lfsr[7:5] == 3'b000) begin
         spring_valid <= 1'b1;
         spring_slot  <= idx;
      end
   end
`else
   assign spring_valid = 1'b0;
   assign spring_slot  = '0;
`endif

   always_comb begin
      plat_x_flat = '0;
      plat_y_flat = '0;
      for (int i = 0; i < NUM_PLAT; i++) begin
         plat_x_flat[9*i +: 9] = plat_x[i];
         plat_y_flat[9*i +: 9] = plat_y[i];
      end
   end

endmodule
